ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Registered execute stage directly downstream of alu_cu in the RV32I pipeline; consumes the 4-bit alu_control code plus two 32-bit operands and produces the ALU result, zero flag and a pass-through tag.
- Valid/ready handshake on both sides with a 2-entry skid buffer, so a stalled consumer (MEM stage) never drops or duplicates an operation and full throughput holds when unstalled.
- Synchronous flush squashes in-flight work on branch mispredict or jump.

Parameters:
- XLEN, 32, operand/result width
- TAG_W, 5, width of opaque side-band tag (rd index) carried alongside each op

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all buffered entries
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept an op this cycle
- alu_control  in  4  op code from alu_cu (RISCV_PKG encodings)
- operand_a  in  XLEN  rs1 or PC
- operand_b  in  XLEN  rs2 or immediate
- in_tag  in  TAG_W  side-band tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  XLEN  ALU result
- zero  out  1  result == 0
- out_tag  out  TAG_W  tag of the presented result

Behaviour:
- Reset (async, rst=1): both entries invalid; out_valid=0, in_ready=1, result=0, zero=1, out_tag=0. The stage leaves reset on the first clk edge after rst deasserts.
- Input transfer when in_valid & in_ready at a rising edge. Output transfer when out_valid & out_ready.
- The result is computed combinationally from the inputs and captured at accept. Latency is 1 cycle: an op accepted at edge N is presented at out_* after edge N when the buffer is empty.
- Ops, all arithmetic mod 2^XLEN:
  - ADD: a+b
  - SUB: a-b
  - AND, OR, XOR: bitwise
  - SLL: a<<b[4:0]
  - SRL: logical a>>b[4:0]
  - SRA: arithmetic a>>>b[4:0]
  - less_than: signed a<b gives 1, else 0
  - less_than_unsigned: unsigned a<b
  - greater_than: signed a>=b (BGE semantics)
  - greater_than_unsigned: unsigned a>=b
  - Any other code, including the NOP value 4'b0000 when it does not alias ADD: result 0.
- zero is derived from the captured result, not recomputed at the output.
- Buffer: main entry (M, drives outputs) and skid entry (S).
- States:
  - EMPTY: M and S invalid
  - ONE: M valid
  - FULL: M and S valid
- in_ready = !S.valid, registered from state. It must not depend combinationally on out_ready.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + output transfer -> ONE; M is loaded with the new op.
  - ONE + accept, no output transfer -> FULL; the new op goes to S.
  - ONE + output transfer only -> EMPTY.
  - FULL + output transfer -> ONE; S moves to M. No accept is possible because in_ready=0.
  - FULL, no output transfer -> FULL; outputs held stable.
- Ordering is strict FIFO. While out_valid=1 and out_ready=0, result, zero and out_tag must not change.
- flush=1 at an edge: M and S invalidated, any same-cycle accept discarded; next cycle out_valid=0, in_ready=1. Flush overrides accept and transfer. A transfer coinciding with flush is still considered consumed by downstream.
- rst asserted mid-operation: immediate clear to the reset values, regardless of clk.

Test Plan:
- Reset then single op: ADD a=5 b=7 accepted, out_ready=1 -> next cycle out_valid=1, result=12, zero=0; following cycle out_valid=0.
- Op coverage at 1 op/cycle, out_ready=1:
  - SUB 3-3 -> result 0, zero=1
  - SRA 0x80000000 by 4 -> 0xF8000000
  - SRL same operands -> 0x08000000
  - less_than a=-1 b=1 -> 1
  - less_than_unsigned same -> 0
  - greater_than_unsigned 0xFFFFFFFF>=1 -> 1
  - shift with b=0x25 uses b[4:0]=5
- Backpressure: 3 back-to-back ops with out_ready=0 -> 2 accepted, in_ready=0 after the second, outputs hold op1. Release out_ready -> op1, op2, op3 delivered in order, no loss or duplication.
- Flush while FULL with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1; the flushed and offered ops never appear.
- Async reset asserted mid-cycle while FULL -> out_valid drops to 0 immediately without waiting for a clk edge; result=0, out_tag=0.
- Random stream of 1000 ops with random in_valid/out_ready -> scoreboard matches a reference ALU model and tags in order.

Source files
------------

// File: rtl/ex_alu_stage.sv
// Registered RV32I execute stage: ALU plus a two-entry skid buffer.
// Results, zero flag and tag are captured at accept and presented in FIFO order.
module ex_alu_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SGE  = 4'b1011;
  localparam logic [3:0] OP_SGEU = 4'b1100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [XLEN-1:0]   r_m_res;
  logic              r_m_zero;
  logic [TAG_W-1:0]  r_m_tag;
  logic [XLEN-1:0]   r_s_res;
  logic              r_s_zero;
  logic [TAG_W-1:0]  r_s_tag;

  logic [XLEN-1:0]   w_res;
  logic              w_zero;
  logic [4:0]        w_sh;
  logic              w_acc;
  logic              w_xfer;

  assign w_sh   = operand_b[4:0];
  assign w_zero = (w_res == '0);
  assign w_acc  = in_valid & r_in_ready;
  assign w_xfer = r_out_valid & out_ready;

  always_comb begin
    w_res = '0;
    case (alu_control)
      OP_ADD:  w_res = operand_a + operand_b;
      OP_SUB:  w_res = operand_a - operand_b;
      OP_AND:  w_res = operand_a & operand_b;
      OP_OR:   w_res = operand_a | operand_b;
      OP_XOR:  w_res = operand_a ^ operand_b;
      OP_SLL:  w_res = operand_a << w_sh;
      OP_SRL:  w_res = operand_a >> w_sh;
      OP_SRA:  w_res = $unsigned($signed(operand_a) >>> w_sh);
      OP_SLT:  w_res = {{(XLEN-1){1'b0}},
                        $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
      OP_SGE:  w_res = {{(XLEN-1){1'b0}},
                        $signed(operand_a) >= $signed(operand_b)};
      OP_SGEU: w_res = {{(XLEN-1){1'b0}}, operand_a >= operand_b};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_m_res     <= '0;
      r_m_zero    <= 1'b1;
      r_m_tag     <= '0;
      r_s_res     <= '0;
      r_s_zero    <= 1'b1;
      r_s_tag     <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_m_res     <= w_res;
            r_m_zero    <= w_zero;
            r_m_tag     <= in_tag;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_acc && w_xfer) begin
            r_m_res  <= w_res;
            r_m_zero <= w_zero;
            r_m_tag  <= in_tag;
          end else if (w_acc) begin
            // M stalled: park the new op in the skid entry
            r_s_res    <= w_res;
            r_s_zero   <= w_zero;
            r_s_tag    <= in_tag;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_xfer) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_xfer) begin
            r_m_res    <= r_s_res;
            r_m_zero   <= r_s_zero;
            r_m_tag    <= r_s_tag;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_m_res;
  assign zero      = r_m_zero;
  assign out_tag   = r_m_tag;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage: expected results queued at accept,
// popped and compared at each output transfer.
module tb_ex_alu_stage;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SGE  = 4'b1011;
  localparam logic [3:0] OP_SGEU = 4'b1100;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  out_tag;

  int checks;
  int errors;
  int n_out;
  logic last_acc;
  logic last_xfer;

  // {tag, zero, result}
  logic [37:0] sb[$];

  ex_alu_stage #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_control(alu_control),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] ext;
    logic [31:0] fa;
    logic [31:0] fb;
    int sh;
    sh = int'(b & 32'h1f);
    fa = a ^ 32'h8000_0000;
    fb = b ^ 32'h8000_0000;
    ext = {{32{a[31]}}, a};
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a + ~b + 32'd1;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA: begin
        ext = ext >> sh;
        return ext[31:0];
      end
      OP_SLT:  return (fa < fb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SGE:  return (fa < fb) ? 32'd0 : 32'd1;
      OP_SGEU: return (a < b) ? 32'd0 : 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // One cycle: drive after negedge, observe before posedge, then cross posedge.
  task automatic step(
    input logic        v,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  tag,
    input logic        ordy,
    input logic        fl,
    input logic [31:0] exp_res,
    input logic        use_exp
  );
    logic [37:0] e;
    logic [31:0] r;
    @(negedge clk);
    in_valid    = v;
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    in_tag      = tag;
    out_ready   = ordy;
    flush       = fl;
    #2;
    last_acc  = in_valid & in_ready;
    last_xfer = out_valid & out_ready;
    if (last_xfer) begin
      n_out++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got tag=%0d res=%h want none",
                 out_tag, result);
      end else begin
        e = sb.pop_front();
        if ({out_tag, zero, result} !== e) begin
          errors++;
          $display("FAIL out got tag=%0d z=%0b res=%h want tag=%0d z=%0b res=%h",
                   out_tag, zero, result, e[37:33], e[32], e[31:0]);
        end
      end
    end
    if (fl) sb.delete();
    else if (last_acc) begin
      r = use_exp ? exp_res : ref_alu(op, a, b);
      sb.push_back({tag, (r == 32'd0), r});
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, OP_NOP, 32'd0, 32'd0, 5'd0, ordy, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    alu_control = OP_NOP;
    operand_a = '0;
    operand_b = '0;
    in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, result, zero, out_tag} !== {1'b0, 1'b1, 32'd0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL reset got v=%0b rdy=%0b res=%h z=%0b tag=%0d want v=0 rdy=1 res=0 z=1 tag=0",
               out_valid, in_ready, result, zero, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    step(1'b1, OP_ADD, 32'd5, 32'd7, 5'd1, 1'b1, 1'b0, 32'd12, 1'b1);
    idle(1'b1);
    checks++;
    if (!last_xfer) begin
      errors++;
      $display("FAIL single_lat got out_valid=0 want 1");
    end
    idle(1'b1);
    checks++;
    if (last_xfer) begin
      errors++;
      $display("FAIL single_after got out_valid=1 want 0");
    end
  endtask

  task automatic test_ops();
    step(1'b1, OP_SUB, 32'd3, 32'd3, 5'd2, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, OP_SRA, 32'h8000_0000, 32'd4, 5'd3, 1'b1, 1'b0, 32'hF800_0000, 1'b1);
    step(1'b1, OP_SRL, 32'h8000_0000, 32'd4, 5'd4, 1'b1, 1'b0, 32'h0800_0000, 1'b1);
    step(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 32'd1, 1'b1);
    step(1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, OP_SGEU, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1, 1'b0, 32'd1, 1'b1);
    step(1'b1, OP_SGE, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, OP_SLL, 32'd1, 32'h25, 5'd9, 1'b1, 1'b0, 32'd32, 1'b1);
    step(1'b1, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd10, 1'b1, 1'b0, 32'h0F0F_F0F0, 1'b1);
    step(1'b1, OP_OR, 32'h0000_00F0, 32'h0000_000F, 5'd11, 1'b1, 1'b0, 32'h0000_00FF, 1'b1);
    step(1'b1, OP_AND, 32'h0000_00F0, 32'h0000_003C, 5'd12, 1'b1, 1'b0, 32'h0000_0030, 1'b1);
    step(1'b1, OP_NOP, 32'd9, 32'd9, 5'd13, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 4'b1111, 32'd9, 32'd9, 5'd14, 1'b1, 1'b0, 32'd0, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    int n0;
    int acc;
    n0 = n_out;
    acc = 0;
    step(1'b1, OP_ADD, 32'd100, 32'd1, 5'd21, 1'b0, 1'b0, 32'd101, 1'b1);
    acc += int'(last_acc);
    step(1'b1, OP_ADD, 32'd200, 32'd2, 5'd22, 1'b0, 1'b0, 32'd202, 1'b1);
    acc += int'(last_acc);
    step(1'b1, OP_ADD, 32'd300, 32'd3, 5'd23, 1'b0, 1'b0, 32'd303, 1'b1);
    acc += int'(last_acc);
    #1;
    checks++;
    if (acc != 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got acc=%0d rdy=%0b want acc=2 rdy=0", acc, in_ready);
    end
    checks++;
    if ({out_valid, out_tag, result} !== {1'b1, 5'd21, 32'd101}) begin
      errors++;
      $display("FAIL bp_hold got v=%0b tag=%0d res=%h want v=1 tag=21 res=65",
               out_valid, out_tag, result);
    end
    for (int i = 0; i < 10 && !last_acc; i++)
      step(1'b1, OP_ADD, 32'd300, 32'd3, 5'd23, 1'b1, 1'b0, 32'd303, 1'b1);
    drain();
    checks++;
    if (n_out - n0 != 3) begin
      errors++;
      $display("FAIL bp_count got %0d want 3", n_out - n0);
    end
  endtask

  task automatic test_flush();
    step(1'b1, OP_ADD, 32'd1, 32'd1, 5'd24, 1'b0, 1'b0, 32'd2, 1'b1);
    step(1'b1, OP_ADD, 32'd2, 32'd2, 5'd25, 1'b0, 1'b0, 32'd4, 1'b1);
    step(1'b1, OP_ADD, 32'd3, 32'd3, 5'd26, 1'b0, 1'b1, 32'd6, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
    end
    repeat (3) idle(1'b1);
    drain();
  endtask

  task automatic test_async_reset();
    step(1'b1, OP_ADD, 32'd7, 32'd7, 5'd27, 1'b0, 1'b0, 32'd14, 1'b1);
    step(1'b1, OP_ADD, 32'd8, 32'd8, 5'd28, 1'b0, 1'b0, 32'd16, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, result, zero, out_tag} !== {1'b0, 1'b1, 32'd0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL async_rst got v=%0b rdy=%0b res=%h z=%0b tag=%0d want v=0 rdy=1 res=0 z=1 tag=0",
               out_valid, in_ready, result, zero, out_tag);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) idle(1'b1);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 1000; i++) begin
      op = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), op, $urandom, $urandom,
           5'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0, 32'd0, 1'b0);
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_out = 0;
    last_acc = 1'b0;
    last_xfer = 1'b0;
    test_reset();
    test_single();
    test_ops();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
